// File: rtl/button_event_arbiter.sv
// Turns debounced button presses into queued events on one valid/ready channel.
// Ports: clk, rst (async, active-high); btn_lvl/enable in; evt_valid/evt_id/evt_onehot out,
//   evt_ready in; overflow out (sticky), clr_overflow in.
module button_event_arbiter #(
  parameter int NUM_BTNS = 4,
  parameter int IDW      = $clog2(NUM_BTNS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_lvl,
  input  logic                enable,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [IDW-1:0]      evt_id,
  output logic [NUM_BTNS-1:0] evt_onehot,
  output logic                overflow,
  input  logic                clr_overflow
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t state_q, state_d;

  logic [NUM_BTNS-1:0] lvl_q;
  logic [NUM_BTNS-1:0] pending_q;
  logic [NUM_BTNS-1:0] pending_d;
  logic [NUM_BTNS-1:0] rise;
  logic [NUM_BTNS-1:0] cap;
  logic [NUM_BTNS-1:0] clr_vec;
  logic [IDW-1:0]      ptr_q;
  logic [IDW-1:0]      ptr_d;
  logic [IDW-1:0]      win;
  logic                found;
  logic                any_pend;
  logic                hs;
  logic                load;
  logic                ovf_set;

  assign rise     = btn_lvl & ~lvl_q;
  assign cap      = enable ? rise : '0;
  assign any_pend = |pending_q;
  assign hs       = evt_valid & evt_ready;

  // Rotating search: offset k from ptr, first set bit wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_BTNS; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NUM_BTNS;
      if (!found && pending_q[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  always_comb begin
    if (int'(win) == NUM_BTNS - 1) begin
      ptr_d = '0;
    end else begin
      ptr_d = win + IDW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_pend) begin
          load    = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (hs) begin
          if (any_pend) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The slot handed to the output register frees up this cycle,
  // so a same-cycle re-press refills it instead of overflowing.
  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      clr_vec[i] = load && (int'(win) == i);
    end
  end

  assign ovf_set   = |(cap & pending_q & ~clr_vec);
  assign pending_d = (pending_q & ~clr_vec) | cap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lvl_q     <= '1;
      pending_q <= '0;
      ptr_q     <= '0;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lvl_q     <= btn_lvl;
      pending_q <= pending_d;
      if (load) begin
        ptr_q     <= ptr_d;
        evt_valid <= 1'b1;
        evt_id    <= win;
      end else if (hs) begin
        evt_valid <= 1'b0;
      end
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    evt_onehot = '0;
    if (evt_valid) begin
      evt_onehot[evt_id] = 1'b1;
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Self-checking bench for button_event_arbiter.
// Directed scenarios plus random traffic against a rule-level reference model.
module tb_button_event_arbiter;

  localparam int N   = 4;
  localparam int IDW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   btn_lvl;
  logic           enable;
  logic           evt_valid;
  logic           evt_ready;
  logic [IDW-1:0] evt_id;
  logic [N-1:0]   evt_onehot;
  logic           overflow;
  logic           clr_overflow;

  int n_chk  = 0;
  int n_pass = 0;

  button_event_arbiter #(.NUM_BTNS(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_lvl      (btn_lvl),
    .enable       (enable),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_id       (evt_id),
    .evt_onehot   (evt_onehot),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  // Reference model: per-button mailbox bits, one presented slot.
  bit m_pend[N];
  bit m_lvl[N];
  int m_ptr;
  bit m_valid;
  int m_id;
  bit m_ovf;
  int delivered[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0;
      m_lvl[i]  = 1;
    end
    m_ptr = 0; m_valid = 0; m_id = 0; m_ovf = 0;
  endtask

  task automatic model_edge();
    int  w;
    bit  accepted, take, ovf_now;
    bit  np[N];
    accepted = m_valid && evt_ready;
    if (accepted) delivered.push_back(m_id);
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && m_pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    take = (w >= 0) && (!m_valid || accepted);
    ovf_now = 0;
    for (int i = 0; i < N; i++) begin
      bit pressed, freed;
      pressed = btn_lvl[i] && !m_lvl[i] && enable;
      freed   = take && (w == i);
      np[i]   = freed ? 1'b0 : m_pend[i];
      if (pressed) begin
        if (m_pend[i] && !freed) ovf_now = 1;
        else np[i] = 1;
      end
      m_lvl[i] = btn_lvl[i];
    end
    m_pend = np;
    if (take) begin
      m_valid = 1; m_id = w; m_ptr = (w + 1) % N;
    end else if (accepted) begin
      m_valid = 0;
    end
    if (ovf_now) m_ovf = 1;
    else if (clr_overflow) m_ovf = 0;
  endtask

  task automatic compare(input string tag);
    logic [N-1:0] oh;
    oh = m_valid ? N'(1) << m_id : '0;
    check({tag, ".valid"}, 32'(evt_valid), 32'(m_valid));
    if (m_valid) check({tag, ".id"}, 32'(evt_id), 32'(m_id));
    check({tag, ".onehot"}, 32'(evt_onehot), 32'(oh));
    check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
  endtask

  // One clock: inputs already set by caller; model follows the edge.
  task automatic step(input string tag);
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    compare(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    step("rst");
    step("rst");
    rst = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int c;
    evt_ready = 1'b1;
    c = 0;
    while ((m_valid || evt_valid) && c < budget) begin
      step(tag);
      c++;
    end
    check({tag, ".drained"}, 32'(evt_valid), 32'd0);
  endtask

  initial begin
    btn_lvl = '0; enable = 1'b1; evt_ready = 1'b0; clr_overflow = 1'b0;
    rst = 1'b1;
    #2;
    model_reset();
    check("reset.valid", 32'(evt_valid), 32'd0);
    check("reset.onehot", 32'(evt_onehot), 32'd0);
    check("reset.ovf", 32'(overflow), 32'd0);

    // Held through reset.
    btn_lvl = 4'b0010;
    step("hold_rst");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step("hold");
      check("hold.noevt", 32'(evt_valid), 32'd0);
    end
    btn_lvl = 4'b0000;
    step("rel");
    btn_lvl = 4'b0010;
    step("press1");
    check("lat.edge1", 32'(evt_valid), 32'd0);
    step("press1b");
    check("lat.valid", 32'(evt_valid), 32'd1);
    check("lat.id", 32'(evt_id), 32'd1);
    check("lat.onehot", 32'(evt_onehot), 32'b0010);
    drain("d0", 10);

    // Simultaneous press, round-robin order.
    do_reset();
    btn_lvl = '0; evt_ready = 1'b1;
    step("sim0");
    btn_lvl = 4'b1111;
    step("sim1");
    for (int i = 0; i < 4; i++) begin
      step("sim");
      check("sim.id", 32'(evt_id), 32'(i));
      check("sim.valid", 32'(evt_valid), 32'd1);
    end
    step("sim.end");
    check("sim.drop", 32'(evt_valid), 32'd0);

    // Fairness: button 2, then 0 and 3 together.
    btn_lvl = '0;
    step("f0");
    btn_lvl = 4'b0100;
    step("f1");
    step("f2");
    check("fair.first", 32'(evt_id), 32'd2);
    btn_lvl = '0;
    step("f3");
    btn_lvl = 4'b1001;
    step("f4");
    step("f5");
    check("fair.a", 32'(evt_id), 32'd3);
    step("f6");
    check("fair.b", 32'(evt_id), 32'd0);
    drain("d1", 10);

    // Backpressure and overflow.
    delivered.delete();
    evt_ready = 1'b0; btn_lvl = '0;
    step("bp0");
    btn_lvl = 4'b0001; step("bp1"); step("bp2");
    for (int i = 0; i < 3; i++) step("bp.hold");
    btn_lvl = '0; step("bp3");
    btn_lvl = 4'b0001; step("bp4");
    check("bp.noovf", 32'(overflow), 32'd0);
    btn_lvl = '0; step("bp5");
    btn_lvl = 4'b0001; step("bp6");
    check("bp.ovf", 32'(overflow), 32'd1);
    btn_lvl = '0;
    drain("bp.drain", 10);
    check("bp.count", 32'(delivered.size()), 32'd2);
    clr_overflow = 1'b1; step("clr"); clr_overflow = 1'b0;
    check("clr.ovf", 32'(overflow), 32'd0);
    evt_ready = 1'b0;
    btn_lvl = 4'b0100; step("c1"); step("c2");
    btn_lvl = '0; step("c3");
    btn_lvl = 4'b0100; step("c4");
    btn_lvl = '0; step("c5");
    btn_lvl = 4'b0100; clr_overflow = 1'b1; step("c6");
    clr_overflow = 1'b0;
    check("clr.setwins", 32'(overflow), 32'd1);
    btn_lvl = '0;
    drain("d2", 10);

    // Enable gating.
    enable = 1'b0; btn_lvl = 4'b0100; step("en0"); step("en1"); step("en2");
    check("en.blocked", 32'(evt_valid), 32'd0);
    btn_lvl = '0; enable = 1'b1; evt_ready = 1'b0; step("en3");
    btn_lvl = 4'b0010; step("en4");
    enable = 1'b0; step("en5"); step("en6");
    evt_ready = 1'b1; step("en7");
    check("en.deliv", 32'(evt_id), 32'd1);
    enable = 1'b1; btn_lvl = '0;
    drain("d3", 10);

    // Reset mid-handshake with two pending.
    evt_ready = 1'b0;
    btn_lvl = 4'b0111; step("mr0"); step("mr1");
    check("mr.valid", 32'(evt_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("mr.async", 32'(evt_valid), 32'd0);
    step("mr.rst");
    rst = 1'b0; btn_lvl = '0; evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) step("mr.stale");

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(2) == 0) btn_lvl[i] = ~btn_lvl[i];
      enable       = ($urandom_range(7) != 0);
      evt_ready    = ($urandom_range(2) != 0);
      clr_overflow = ($urandom_range(15) == 0);
      step("rnd");
    end
    btn_lvl = '0; clr_overflow = 1'b0;
    drain("d4", 20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Collects debounced button levels from the per-button `debounce` instances and turns each press into a single queued event. Events from all buttons share one valid/ready event channel to the game control FSM. Access to that channel is round-robin, so no button can starve another. Each button buffers one pending event, a sticky flag reports any lost press, and the block sits between the debounce bank and the guessing-game controller.

## Interface
- `NUM_BTNS`, default 4: number of button inputs, legal range 2..16.
- `IDW`, default `$clog2(NUM_BTNS)`: width of the event ID. It is derived, and the parent does not override it.

- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `btn_lvl`, in, NUM_BTNS: debounced button levels, already synchronous to `clk`; 1 = pressed.
- `enable`, in, 1: when 1, new presses are captured; when 0, new presses are ignored.
- `evt_valid`, out, 1: an event is presented.
- `evt_ready`, in, 1: the consumer accepts the event.
- `evt_id`, out, IDW: index of the button that produced the event.
- `evt_onehot`, out, NUM_BTNS: `1 << evt_id` when `evt_valid` is 1, otherwise all zeros.
- `overflow`, out, 1: sticky flag; set when a press is lost.
- `clr_overflow`, in, 1: synchronous clear for `overflow`.

## Operation
- **Registers**
  - `lvl_q[N]`: previous button level.
  - `pending[N]`: one buffered event per button.
  - `ptr`: round-robin start index, IDW bits.
  - Output register: `evt_valid`, `evt_id`.
  - `overflow`.
  - Two-state FSM: IDLE and PRESENT.
- **Press detect**
  - `rise = btn_lvl & ~lvl_q`.
  - `lvl_q <= btn_lvl` every cycle, regardless of `enable`.
- **Capture**
  - If `rise[i] & enable`, then `pending[i]` is set.
  - If `pending[i]` is already 1 and is not being cleared in the same cycle, `overflow` is set instead; the press is dropped.
- **Selection**
  - Search `pending` from `ptr` upward, wrapping modulo `NUM_BTNS`.
  - The first set bit is the winner `w`.
- **Load**
  - Occurs in IDLE when any pending bit is set, or in PRESENT on the handshake cycle (`evt_valid & evt_ready`) when any pending bit is set.
  - Load action: `evt_id <= w`, `evt_valid <= 1`, `pending[w] <= 0`, `ptr <= (w+1) mod NUM_BTNS`.
  - The FSM goes to, or stays in, PRESENT.
- **Handshake with nothing pending:** `evt_valid <= 0`, FSM goes to IDLE.
- **PRESENT without `evt_ready`:** `evt_valid` and `evt_id` hold stable. Valid never drops without an accept.
- **Same-button re-press:** a rise on button `i` in the same cycle that `pending[i]` is loaded into the output register sets `pending[i]` again. This is not an overflow, because the output register and `pending` count as separate slots.
- **`enable` = 0:** blocks new captures only. Already-pending events are still delivered.
- **`overflow` priority:** set wins over a simultaneous `clr_overflow`.
- **Pressed at reset:** `lvl_q` resets to all ones, so a button held through reset produces no event until it is released and pressed again.

## Timing
- **Reset values (asynchronous, immediate):**
  - `evt_valid` = 0, `evt_id` = 0, `evt_onehot` = 0, `overflow` = 0.
  - `pending` = 0, `ptr` = 0, FSM = IDLE, `lvl_q` = all ones.
- **Reset mid-handshake:** the presented event and all pending events are discarded.
- **Latency:** `btn_lvl[i]` rises and is sampled at edge k. `pending[i]` is set at edge k. `evt_valid` = 1 with `evt_id` = i after edge k+1.
- **Throughput:** with `evt_ready` held at 1, one event per cycle, and `evt_valid` stays high across back-to-back events.
- **Outputs:** all registered except `evt_onehot`, which is a combinational decode of registered `evt_valid` and `evt_id`.
- **Inputs:** `evt_ready` is sampled only while `evt_valid` = 1. `clr_overflow` is sampled every cycle.

## Test plan
- **Held through reset:** `btn_lvl` = 4'b0010 held through reset release gives no event for 10 cycles. Release, then press button 1: `evt_valid` = 1 and `evt_id` = 1 exactly 2 edges after the press, and `evt_onehot` = 4'b0010.
- **Simultaneous press, round-robin order:** from reset, `btn_lvl` goes 0 → 4'b1111 in one cycle with `evt_ready` = 1. Expect `evt_id` = 0, 1, 2, 3 on 4 consecutive cycles, `evt_valid` high for exactly 4 cycles, and `ptr` = 0 afterwards.
- **Fairness:** after one event from button 2 (`ptr` = 3), press buttons 0 and 3 together. Expect `evt_id` = 3 first, then 0.
- **Backpressure and overflow:**
  - With `evt_ready` = 0, press button 0: `evt_valid` = 1, `evt_id` = 0, held stable.
  - Release, press again: `pending[0]` = 1, `overflow` = 0.
  - Release, press a third time: `overflow` = 1.
  - Raise `evt_ready`: exactly 2 events with id 0 are delivered.
  - Pulse `clr_overflow`: `overflow` = 0.
  - Pulse `clr_overflow` in the same cycle as a new overflow: `overflow` stays 1.
- **Enable gating:**
  - With `enable` = 0, press button 2: no event.
  - Press button 1 with `enable` = 1, then drop `enable` while `evt_ready` = 0: the button 1 event is still delivered once `evt_ready` = 1.
- **Reset mid-handshake:** assert `rst` mid-cycle while `evt_valid` = 1 and two events are pending. `evt_valid` drops immediately with no clock edge. After release, no stale events appear.
